alu_sequencer: RTL and testbench

Micro-sequencer that sits directly upstream of the 4-bit ALU and drives its operand and opcode inputs from a 16-entry program memory. It keeps a 4-bit accumulator, presents `{accumulator, immediate, opcode}` to the ALU, and waits a fixed ALU latency before capturing the ALU result and flags. It supports conditional branching on the captured zero flag. Programs are written through a load port while idle and launched with a start pulse.

---
 rtl/alu_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: micro-sequencer that feeds a pipelined 4-bit ALU from a small
// program memory, waits a fixed ALU latency, then captures result and flags.
//
// Ports:
//   clk         system clock, rising edge
//   iRst_n      asynchronous active-low reset
//   iWe         program write strobe (IDLE only)
//   iWAddr      program write address
//   iWData      program word {mode[1:0], op[3:0], imm[3:0]}
//   iStart      start pulse (IDLE only)
//   iResultado  ALU result
//   iFlags      ALU flags {sign, parity, overflow, carry, zero}
//   oA, oB      ALU operands (accumulator copy, immediate)
//   oOpCode     ALU opcode, 4'b1111 when no operation is in flight
//   oAcc        accumulator
//   oFlagReg    last captured ALU flags
//   oPc         program counter
//   oBusy       high in any state except IDLE
//   oDone       one-cycle pulse when HALT executes
module alu_sequencer #(
   parameter int unsigned ALU_LAT = 3,
   parameter int unsigned DEPTH   = 16
) (
   input  logic                     clk,
   input  logic                     iRst_n,
   input  logic                     iWe,
   input  logic [$clog2(DEPTH)-1:0] iWAddr,
   input  logic [9:0]               iWData,
   input  logic                     iStart,
   input  logic [3:0]               iResultado,
   input  logic [4:0]               iFlags,
   output logic [3:0]               oA,
   output logic [3:0]               oB,
   output logic [3:0]               oOpCode,
   output logic [3:0]               oAcc,
   output logic [4:0]               oFlagReg,
   output logic [$clog2(DEPTH)-1:0] oPc,
   output logic                     oBusy,
   output logic                     oDone
);

   localparam int unsigned PC_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W = 3;
   localparam int unsigned DW    = 4;
   localparam int unsigned FW    = 5;
   localparam int unsigned IW    = 10;

   localparam logic [DW-1:0] OP_NOP = 4'b1111;

   localparam logic [1:0] M_EXEC = 2'b00;
   localparam logic [1:0] M_LOAD = 2'b01;
   localparam logic [1:0] M_BRZ  = 2'b10;
   localparam logic [1:0] M_HALT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DECODE = 2'd2,
      ST_WAIT   = 2'd3
   } state_t;

   state_t r_state, w_state_nxt;

   logic [IW-1:0]    r_mem [DEPTH];
   logic [IW-1:0]    r_ir,   w_ir_nxt;
   logic [PC_W-1:0]  r_pc,   w_pc_nxt;
   logic [DW-1:0]    r_acc,  w_acc_nxt;
   logic [FW-1:0]    r_flag, w_flag_nxt;
   logic [DW-1:0]    r_a,    w_a_nxt;
   logic [DW-1:0]    r_b,    w_b_nxt;
   logic [DW-1:0]    r_op,   w_op_nxt;
   logic [CNT_W-1:0] r_cnt,  w_cnt_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;

   logic [PC_W-1:0]  w_pc_inc;
   logic [1:0]       w_mode;
   logic [DW-1:0]    w_ir_op;
   logic [DW-1:0]    w_ir_imm;
   logic             w_we;

   assign w_mode   = r_ir[9:8];
   assign w_ir_op  = r_ir[7:4];
   assign w_ir_imm = r_ir[3:0];
   assign w_we     = iWe && (r_state == ST_IDLE);

   // pc + 1 modulo DEPTH (also correct for non-power-of-two depths)
   assign w_pc_inc = (r_pc == PC_W'(DEPTH - 1)) ? '0 : r_pc + PC_W'(1);

   // Program memory: no reset, contents survive iRst_n
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[iWAddr] <= iWData;
      end
   end

   // State register
   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath next values
   always_comb begin
      w_state_nxt = r_state;
      w_ir_nxt    = r_ir;
      w_pc_nxt    = r_pc;
      w_acc_nxt   = r_acc;
      w_flag_nxt  = r_flag;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_op_nxt    = r_op;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (iStart) begin
               w_pc_nxt    = '0;
               w_acc_nxt   = '0;
               w_flag_nxt  = '0;
               w_state_nxt = ST_FETCH;
            end
         end

         ST_FETCH: begin
            w_ir_nxt    = r_mem[r_pc];
            w_state_nxt = ST_DECODE;
         end

         ST_DECODE: begin
            unique case (w_mode)
               M_EXEC: begin
                  w_a_nxt     = r_acc;
                  w_b_nxt     = w_ir_imm;
                  w_op_nxt    = w_ir_op;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_WAIT;
               end
               M_LOAD: begin
                  w_acc_nxt   = w_ir_imm;
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = ST_FETCH;
               end
               M_BRZ: begin
                  w_pc_nxt    = r_flag[0] ? PC_W'(w_ir_imm) : w_pc_inc;
                  w_state_nxt = ST_FETCH;
               end
               M_HALT: begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
               default: begin
                  w_state_nxt = ST_IDLE;
               end
            endcase
         end

         ST_WAIT: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            // Flags become valid ALU_LAT edges after the operands changed;
            // capture on the following edge
            if (r_cnt == CNT_W'(ALU_LAT)) begin
               w_acc_nxt   = iResultado;
               w_flag_nxt  = iFlags;
               w_pc_nxt    = w_pc_inc;
               w_op_nxt    = OP_NOP;
               w_state_nxt = ST_FETCH;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_ir   <= '0;
         r_pc   <= '0;
         r_acc  <= '0;
         r_flag <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_op   <= OP_NOP;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_ir   <= w_ir_nxt;
         r_pc   <= w_pc_nxt;
         r_acc  <= w_acc_nxt;
         r_flag <= w_flag_nxt;
         r_a    <= w_a_nxt;
         r_b    <= w_b_nxt;
         r_op   <= w_op_nxt;
         r_cnt  <= w_cnt_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign oA       = r_a;
   assign oB       = r_b;
   assign oOpCode  = r_op;
   assign oAcc     = r_acc;
   assign oFlagReg = r_flag;
   assign oPc      = r_pc;
   assign oBusy    = r_busy;
   assign oDone    = r_done;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a 3-stage ALU model
// (operands at e1, result at e2, flags at e3) and a capture-timing stub.
module tb_alu_sequencer;

   logic       clk;
   logic       iRst_n;
   logic       iWe;
   logic [3:0] iWAddr;
   logic [9:0] iWData;
   logic       iStart;
   logic [3:0] iResultado;
   logic [4:0] iFlags;
   logic [3:0] oA, oB, oOpCode, oAcc, oPc;
   logic [4:0] oFlagReg;
   logic       oBusy, oDone;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc;

   alu_sequencer #(.ALU_LAT(3), .DEPTH(16)) u_dut (
      .clk        (clk),
      .iRst_n     (iRst_n),
      .iWe        (iWe),
      .iWAddr     (iWAddr),
      .iWData     (iWData),
      .iStart     (iStart),
      .iResultado (iResultado),
      .iFlags     (iFlags),
      .oA         (oA),
      .oB         (oB),
      .oOpCode    (oOpCode),
      .oAcc       (oAcc),
      .oFlagReg   (oFlagReg),
      .oPc        (oPc),
      .oBusy      (oBusy),
      .oDone      (oDone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU model: {flags, result}; add (0101), subtract (0110), else result 0
   function automatic logic [8:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] op);
      logic [4:0] s;
      logic       ovf;
      s   = 5'd0;
      ovf = 1'b0;
      if (op == 4'b0101) begin
         s   = {1'b0, a} + {1'b0, b};
         ovf = (a[3] == b[3]) && (s[3] != a[3]);
      end else if (op == 4'b0110) begin
         s   = {1'b0, a} - {1'b0, b};
         ovf = (a[3] != b[3]) && (s[3] != a[3]);
      end
      return {s[3], ^s[3:0], ovf, s[4], (s[3:0] == 4'd0), s[3:0]};
   endfunction

   logic [11:0] s1_ops;
   logic [3:0]  s2_res;
   logic [4:0]  s2_fl, s3_fl;
   logic [11:0] stub_ops;
   int          stub_cnt = 0;
   logic        stub_en  = 1'b0;

   always @(posedge clk) begin
      logic [8:0] r;
      r      = alu_f(s1_ops[11:8], s1_ops[7:4], s1_ops[3:0]);
      s1_ops <= {oA, oB, oOpCode};
      s2_res <= r[3:0];
      s2_fl  <= r[8:4];
      s3_fl  <= s2_fl;
      // stub: count edges since the ALU inputs last changed
      if ({oA, oB, oOpCode} != stub_ops) begin
         stub_ops <= {oA, oB, oOpCode};
         stub_cnt <= 1;
      end else if (stub_cnt < 7) begin
         stub_cnt <= stub_cnt + 1;
      end
   end

   assign iResultado = stub_en ? ((stub_cnt >= 3) ? 4'hA  : 4'h5)  : s2_res;
   assign iFlags     = stub_en ? ((stub_cnt >= 3) ? 5'h15 : 5'h0A) : s3_fl;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [9:0] enc(input logic [1:0] m, input logic [3:0] op,
                                      input logic [3:0] imm);
      return {m, op, imm};
   endfunction

   task automatic wr(input logic [3:0] a, input logic [9:0] d);
      iWe = 1'b1; iWAddr = a; iWData = d;
      tick();
      iWe = 1'b0;
   endtask

   task automatic start();
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (!oDone && n < max) begin
         tick();
         n++;
      end
      check("done_seen", 32'(oDone), 32'd1);
   endtask

   task automatic do_reset();
      iRst_n = 1'b0;
      tick();
      iRst_n = 1'b1;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      iRst_n = 1'b0; iWe = 1'b0; iWAddr = '0; iWData = '0; iStart = 1'b0;
      tick(); tick();
      iRst_n = 1'b1;
      tick();

      // Reset state
      check("rst_ab",    32'({oA, oB}), 32'h00);
      check("rst_op",    32'(oOpCode), 32'hF);
      check("rst_acc",   32'(oAcc), 32'h0);
      check("rst_flag",  32'(oFlagReg), 32'h00);
      check("rst_pc",    32'(oPc), 32'h0);
      check("rst_busy",  32'({oBusy, oDone}), 32'h0);

      // LOAD 3; EXEC add imm 4; HALT
      wr(4'd0, enc(2'b01, 4'b0000, 4'd3));
      wr(4'd1, enc(2'b00, 4'b0101, 4'd4));
      wr(4'd2, enc(2'b11, 4'b0000, 4'd0));
      start();
      check("start_busy", 32'(oBusy), 32'd1);
      wait_done(40, cyc);
      check("run_latency", 32'(cyc), 32'd10);
      check("run_acc",     32'(oAcc), 32'd7);
      check("run_flags",   32'(oFlagReg), 32'h08);
      check("run_pc",      32'(oPc), 32'd2);
      check("run_busy",    32'(oBusy), 32'd0);
      tick();
      check("done_pulse",  32'(oDone), 32'd0);

      // Reset in the middle of WAIT
      start();
      repeat (5) tick();
      check("mid_wait_op", 32'(oOpCode), 32'h5);
      #2 iRst_n = 1'b0;
      #1;
      check("arst_op",   32'(oOpCode), 32'hF);
      check("arst_ab",   32'({oA, oB}), 32'h00);
      check("arst_acc",  32'({oAcc, oPc}), 32'h00);
      check("arst_flag", 32'({oFlagReg, oBusy}), 32'h00);
      tick();
      iRst_n = 1'b1;
      tick();
      start();
      wait_done(40, cyc);
      check("mem_kept_lat", 32'(cyc), 32'd10);
      check("mem_kept_acc", 32'(oAcc), 32'd7);
      tick();

      // Capture timing with the stub
      stub_en = 1'b1;
      wr(4'd0, enc(2'b01, 4'b0000, 4'd2));
      start();
      repeat (4) tick();
      for (int k = 0; k < 4; k++) begin
         check("wait_stable", 32'({oA, oB, oOpCode, oAcc}), 32'h2452);
         tick();
      end
      check("cap_acc",  32'(oAcc), 32'hA);
      check("cap_flag", 32'(oFlagReg), 32'h15);
      check("cap_ops",  32'({oA, oB, oOpCode}), 32'h24F);
      check("cap_pc",   32'(oPc), 32'd2);
      wait_done(20, cyc);
      stub_en = 1'b0;
      tick();

      // Branch taken
      wr(4'd0, enc(2'b01, 4'b0000, 4'd5));
      wr(4'd1, enc(2'b00, 4'b0110, 4'd5));
      wr(4'd2, enc(2'b10, 4'b0000, 4'd7));
      wr(4'd3, enc(2'b11, 4'b0000, 4'd0));
      wr(4'd7, enc(2'b11, 4'b0000, 4'd0));
      start();
      wait_done(60, cyc);
      check("brz_t_lat",  32'(cyc), 32'd12);
      check("brz_t_pc",   32'(oPc), 32'd7);
      check("brz_t_acc",  32'(oAcc), 32'd0);
      check("brz_t_zero", 32'(oFlagReg[0]), 32'd1);
      tick();

      // Branch not taken
      wr(4'd1, enc(2'b00, 4'b0110, 4'd4));
      start();
      wait_done(60, cyc);
      check("brz_n_lat",  32'(cyc), 32'd12);
      check("brz_n_pc",   32'(oPc), 32'd3);
      check("brz_n_acc",  32'(oAcc), 32'd1);
      check("brz_n_zero", 32'(oFlagReg[0]), 32'd0);
      tick();

      // Wrap-around with 16 LOADs and no HALT
      for (int i = 0; i < 16; i++) wr(4'(i), enc(2'b01, 4'b0000, 4'(i)));
      start();
      repeat (32) tick();
      check("wrap_pc",   32'(oPc), 32'd0);
      check("wrap_acc",  32'(oAcc), 32'hF);
      check("wrap_busy", 32'(oBusy), 32'd1);
      repeat (2) tick();
      check("wrap_cont", 32'({oPc, oAcc}), 32'h10);

      // Write and start while busy must be ignored
      iStart = 1'b1; iWe = 1'b1; iWAddr = 4'd5; iWData = enc(2'b11, 4'b0000, 4'd0);
      tick();
      iStart = 1'b0; iWe = 1'b0;
      tick();
      check("busy_nostart", 32'(oPc), 32'd2);
      repeat (32) tick();
      check("busy_nowrite", 32'({oPc, oAcc}), 32'h21);
      check("busy_still",   32'(oBusy), 32'd1);
      do_reset();

      // Simultaneous write and start at address 0: new word executes first
      iStart = 1'b1; iWe = 1'b1; iWAddr = 4'd0; iWData = enc(2'b11, 4'b0000, 4'd0);
      tick();
      iStart = 1'b0; iWe = 1'b0;
      wait_done(20, cyc);
      check("ws_lat",  32'(cyc), 32'd2);
      check("ws_pc",   32'({oPc, oAcc}), 32'h00);
      check("ws_busy", 32'(oBusy), 32'd0);
      tick();
      check("ws_done_pulse", 32'(oDone), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
